periph_bus_initiator: RTL and testbench
=======================================

Name: periph_bus_initiator

Overview:
- Single-outstanding initiator (master end) of the XBAR_PERIPH_BUS peripheral protocol.
- Accepts read/write commands from a local valid/ready port and drives req/addr/wen/wdata/be/id onto the bus.
- Waits for gnt, then for the matching r_valid, and returns rdata/error on a valid/ready response port.
- Used by cluster-side control logic to program peripheral registers such as the lockstep control register at 32'h10204400.

Parameters:
- ID_WIDTH, 5, width of the bus id / r_id fields.
- MASTER_ID, 0, constant value driven on periph_id_o; responses are accepted only when r_id matches it.
- TIMEOUT_CYCLES, 256, response timeout limit; used only with PERIPH_INIT_TIMEOUT_EN; must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- cmd_be_i  in  4  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_err_o  out  1  error: r_opc = 1, or timeout
- periph_req_o  out  1  bus request
- periph_addr_o  out  32  bus address
- periph_wen_o  out  1  0 = write, 1 = read
- periph_wdata_o  out  32  bus write data
- periph_be_o  out  4  bus byte enables
- periph_id_o  out  ID_WIDTH  always MASTER_ID
- periph_gnt_i  in  1  bus grant
- periph_r_valid_i  in  1  response valid
- periph_r_opc_i  in  1  response error flag
- periph_r_id_i  in  ID_WIDTH  response id
- periph_r_rdata_i  in  32  response read data

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
  - All outputs are registered except cmd_ready_o, which is decoded from state.
- Reset values:
  - State = IDLE.
  - periph_req_o = 0, periph_addr_o = 0, periph_wen_o = 1, periph_wdata_o = 0, periph_be_o = 0.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - cmd_ready_o = 1 (IDLE decode).
  - periph_id_o = MASTER_ID at all times.
- States: IDLE, REQ, WAIT, RSP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: capture the command into the bus registers, periph_wen_o = ~cmd_we_i, set periph_req_o = 1, go to REQ.
  - Bus request appears the cycle after acceptance.
- REQ:
  - periph_req_o held high; addr/wen/wdata/be held stable until grant.
  - On periph_gnt_i = 1: clear periph_req_o next cycle, go to WAIT.
  - periph_r_valid_i is ignored in REQ.
- WAIT:
  - On periph_r_valid_i & (periph_r_id_i == MASTER_ID): capture rsp_err_o = periph_r_opc_i.
  - rsp_rdata_o = periph_r_rdata_i for reads, 0 for writes.
  - Set rsp_valid_o = 1, go to RSP.
  - r_valid carrying any other id is ignored.
- RSP:
  - rsp_valid_o and rsp data held stable until rsp_ready_i.
  - On rsp_ready_i: clear rsp_valid_o, go to IDLE.
  - cmd_ready_o = 0, so a new command is never accepted in the same cycle as a response is consumed.
- Minimum latency:
  - Acceptance at edge N → req visible in cycle N+1.
  - With gnt in N+1 and r_valid in N+2, rsp_valid_o is high in N+3.
  - Back-to-back throughput is one transaction per 4 cycles.
- cmd_ready_o = 0 in REQ, WAIT and RSP.
- Reset mid-transaction: immediate return to IDLE with the reset values above. An in-flight bus response arriving afterwards is ignored (IDLE does not sample r_valid).

Optional Feature:
- Macro: PERIPH_INIT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and counts every cycle in REQ and WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: drop periph_req_o, set rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 32'h0, go to RSP.
  - A later stray r_valid is ignored.
  - A completion in the same cycle as the timeout takes priority, i.e. a normal response.
- Not defined: no counter is present; REQ/WAIT wait indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Write, zero-wait slave:
  - Stimulus: cmd we=1, addr=32'h10204400, wdata=32'h00000001, be=4'hF; gnt in the req cycle; r_valid next cycle with r_opc=0, r_id=MASTER_ID.
  - Response: bus shows wen=0 with the given addr/wdata/be for exactly 1 req cycle; rsp_valid_o high 3 cycles after acceptance, rsp_err_o=0, rsp_rdata_o=0.
- Read, stalled grant:
  - Stimulus: cmd we=0, addr=32'h10204400; gnt withheld 5 cycles; r_rdata=32'hCAFE0001.
  - Response: req held high and stable for 6 cycles, wen=1; rsp_rdata_o=32'hCAFE0001; rsp_valid_o held with rsp_ready_i low for 4 cycles, cmd_ready_o=0 throughout.
- Error and id filter:
  - Stimulus: during WAIT, r_valid with r_id=MASTER_ID+1, then next cycle r_valid with r_id=MASTER_ID, r_opc=1.
  - Response: the first is ignored; response completes with rsp_err_o=1.
- Reset mid-operation:
  - Stimulus: assert rst_i for 1 cycle while in WAIT, then drive r_valid.
  - Response: all outputs at reset values next cycle, cmd_ready_o=1, no rsp_valid_o.
- Timeout (PERIPH_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: gnt given, r_valid never asserted.
  - Response: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 after 16 cycles counted from REQ entry; a late r_valid is ignored.

Source files
------------

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: single-outstanding master for the XBAR_PERIPH_BUS
// peripheral protocol. A local valid/ready command is put on the bus,
// the initiator waits for gnt and then for an r_valid tagged with its own
// id, and the result is returned on a valid/ready response port.
// Optional response timeout: define PERIPH_INIT_TIMEOUT_EN.
module periph_bus_initiator #(
  parameter int                  ID_WIDTH       = 5,
  parameter logic [ID_WIDTH-1:0] MASTER_ID      = '0,
  parameter int                  TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                periph_req_o,
  output logic [31:0]         periph_addr_o,
  output logic                periph_wen_o,
  output logic [31:0]         periph_wdata_o,
  output logic [3:0]          periph_be_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_gnt_i,
  input  logic                periph_r_valid_i,
  input  logic                periph_r_opc_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i,
  input  logic [31:0]         periph_r_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  // The timeout counter needs at least one cycle in REQ before it can fire.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_hit;
  logic        timeout_hit;

  // A response counts only when it carries our own id.
  assign rsp_hit = periph_r_valid_i && (periph_r_id_i == MASTER_ID);

`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycle counter: zero outside a transaction, so it restarts on REQ entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == REQ || state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // >= keeps the limit sticky if a late grant pushes the count past it.
  assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode; completions beat the timeout.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wen_d   = ~cmd_we_i;
          wdata_d = cmd_wdata_i;
          be_d    = cmd_be_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end else if (timeout_hit) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      WAIT: begin
        if (rsp_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = periph_r_opc_i;
          rsp_rdata_d = wen_q ? periph_r_rdata_i : 32'h0;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b1;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign periph_req_o   = req_q;
  assign periph_addr_o  = addr_q;
  assign periph_wen_o   = wen_q;
  assign periph_wdata_o = wdata_q;
  assign periph_be_o    = be_q;
  assign periph_id_o    = MASTER_ID;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Testbench for periph_bus_initiator. Build with +define+PERIPH_INIT_TIMEOUT_EN
// to exercise the response timeout (TIMEOUT_CYCLES = 16 in that build).
module tb_periph_bus_initiator;

  localparam int         IDW = 5;
  localparam logic [4:0] MID = 5'd3;
`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 256;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic            cmd_we_i = 1'b0;
  logic [31:0]     cmd_addr_i = '0;
  logic [31:0]     cmd_wdata_i = '0;
  logic [3:0]      cmd_be_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_err_o;
  logic            periph_req_o;
  logic [31:0]     periph_addr_o;
  logic            periph_wen_o;
  logic [31:0]     periph_wdata_o;
  logic [3:0]      periph_be_o;
  logic [IDW-1:0]  periph_id_o;
  logic            periph_gnt_i = 1'b0;
  logic            periph_r_valid_i = 1'b0;
  logic            periph_r_opc_i = 1'b0;
  logic [IDW-1:0]  periph_r_id_i = '0;
  logic [31:0]     periph_r_rdata_i = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  periph_bus_initiator #(
    .ID_WIDTH(IDW), .MASTER_ID(MID), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .periph_req_o(periph_req_o), .periph_addr_o(periph_addr_o),
    .periph_wen_o(periph_wen_o), .periph_wdata_o(periph_wdata_o),
    .periph_be_o(periph_be_o), .periph_id_o(periph_id_o),
    .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_opc_i(periph_r_opc_i), .periph_r_id_i(periph_r_id_i),
    .periph_r_rdata_i(periph_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Observations from the most recent transaction.
  logic        o_rdy_before, o_bus_ok, o_req_after, o_hold_ok, o_valid_after, o_ready_after;
  int          o_req_cycles, o_lat;
  logic [31:0] o_rdata;
  logic        o_err;

  // Bus-slave driver: grants after g stall cycles, answers after w WAIT cycles,
  // then leaves the response pending for rd cycles. With junk set, a matching
  // r_valid is shown during REQ and wrong-id r_valid pulses during WAIT.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int g, input int w,
                         input logic [31:0] srdata, input logic sopc, input int rd,
                         input logic junk);
    int cyc;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_be_i = be;
    o_rdy_before = cmd_ready_o;
    tick();
    cmd_valid_i = 1'b0;
    cmd_we_i = ~we; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_be_i = 4'($urandom);
    cyc = 1; o_req_cycles = 0; o_bus_ok = 1'b1;
    for (int i = 0; i <= g; i++) begin
      if (periph_req_o === 1'b1) o_req_cycles++;
      if (periph_addr_o !== addr || periph_wen_o !== ~we || periph_wdata_o !== wdata ||
          periph_be_o !== be || periph_id_o !== MID) o_bus_ok = 1'b0;
      periph_gnt_i = (i == g);
      periph_r_valid_i = junk; periph_r_id_i = MID; periph_r_rdata_i = $urandom;
      tick(); cyc++;
    end
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0;
    o_req_after = periph_req_o;
    for (int i = 0; i <= w; i++) begin
      if (i == w) begin
        periph_r_valid_i = 1'b1; periph_r_id_i = MID;
        periph_r_rdata_i = srdata; periph_r_opc_i = sopc;
      end else begin
        periph_r_valid_i = junk; periph_r_id_i = MID + 5'd1;
        periph_r_rdata_i = $urandom; periph_r_opc_i = ~sopc;
      end
      tick(); cyc++;
    end
    periph_r_valid_i = 1'b0; periph_r_rdata_i = $urandom; periph_r_opc_i = 1'b0;
    o_lat = -1;
    for (int k = 0; k < 24; k++) begin
      if (rsp_valid_o === 1'b1) begin o_lat = cyc; break; end
      tick(); cyc++;
    end
    o_rdata = rsp_rdata_o; o_err = rsp_err_o; o_hold_ok = 1'b1;
    for (int i = 0; i < rd; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== o_rdata || rsp_err_o !== o_err ||
          cmd_ready_o !== 1'b0) o_hold_ok = 1'b0;
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    o_valid_after = rsp_valid_o; o_ready_after = cmd_ready_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    total_cnt++;
    if (periph_req_o !== 1'b0 || periph_addr_o !== 32'h0 || periph_wen_o !== 1'b1 ||
        periph_wdata_o !== 32'h0 || periph_be_o !== 4'h0 || periph_id_o !== MID)
      $display("FAIL reset_bus: req=%b addr=%h wen=%b wdata=%h be=%h id=%0d required 0/0/1/0/0/%0d",
               periph_req_o, periph_addr_o, periph_wen_o, periph_wdata_o, periph_be_o, periph_id_o, MID);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || cmd_ready_o !== 1'b1)
      $display("FAIL reset_rsp: valid=%b rdata=%h err=%b cmd_ready=%b required 0/0/0/1",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, cmd_ready_o);
    else pass_cnt++;
    $display("reset: checked");
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 32'h10204400, 32'h00000001, 4'hF, 0, 0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    $display("write zero-wait: req_cycles=%0d lat=%0d rdata=%h err=%b", o_req_cycles, o_lat, o_rdata, o_err);
    total_cnt++;
    if (o_rdy_before !== 1'b1 || o_bus_ok !== 1'b1 || o_req_cycles != 1 || o_req_after !== 1'b0)
      $display("FAIL wr_bus: ready=%b bus_ok=%b req_cycles=%0d req_after=%b required 1/1/1/0",
               o_rdy_before, o_bus_ok, o_req_cycles, o_req_after);
    else pass_cnt++;
    total_cnt++;
    if (o_lat != 3) $display("FAIL wr_latency: got %0d required 3", o_lat); else pass_cnt++;
    total_cnt++;
    if (o_rdata !== 32'h0 || o_err !== 1'b0)
      $display("FAIL wr_rsp: rdata=%h err=%b required 00000000/0", o_rdata, o_err);
    else pass_cnt++;
    total_cnt++;
    if (o_valid_after !== 1'b0 || o_ready_after !== 1'b1)
      $display("FAIL wr_release: valid=%b cmd_ready=%b required 0/1", o_valid_after, o_ready_after);
    else pass_cnt++;
  endtask

  task automatic test_read_stall();
    run_txn(1'b0, 32'h10204400, 32'h12345678, 4'hF, 5, 0, 32'hCAFE0001, 1'b0, 4, 1'b0);
    $display("read stalled: req_cycles=%0d lat=%0d rdata=%h err=%b", o_req_cycles, o_lat, o_rdata, o_err);
    total_cnt++;
    if (o_bus_ok !== 1'b1 || o_req_cycles != 6 || o_req_after !== 1'b0)
      $display("FAIL rd_req_hold: bus_ok=%b req_cycles=%0d req_after=%b required 1/6/0",
               o_bus_ok, o_req_cycles, o_req_after);
    else pass_cnt++;
    total_cnt++;
    if (o_lat != 8) $display("FAIL rd_latency: got %0d required 8", o_lat); else pass_cnt++;
    total_cnt++;
    if (o_rdata !== 32'hCAFE0001 || o_err !== 1'b0)
      $display("FAIL rd_rsp: rdata=%h err=%b required cafe0001/0", o_rdata, o_err);
    else pass_cnt++;
    total_cnt++;
    if (o_hold_ok !== 1'b1) $display("FAIL rd_rsp_hold: hold_ok=%b required 1", o_hold_ok);
    else pass_cnt++;
  endtask

  task automatic test_err_id_filter();
    run_txn(1'b0, 32'h00000040, 32'h0, 4'h3, 1, 1, 32'h0BADF00D, 1'b1, 1, 1'b1);
    $display("error/id filter: lat=%0d rdata=%h err=%b", o_lat, o_rdata, o_err);
    total_cnt++;
    if (o_lat != 5) $display("FAIL idf_latency: got %0d required 5", o_lat); else pass_cnt++;
    total_cnt++;
    if (o_rdata !== 32'h0BADF00D || o_err !== 1'b1)
      $display("FAIL idf_rsp: rdata=%h err=%b required 0badf00d/1", o_rdata, o_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen_valid = 1'b0, ready_ok = 1'b1;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'hA5A5A5A4;
    cmd_wdata_i = 32'h5A5A5A5A; cmd_be_i = 4'hC;
    tick();
    cmd_valid_i = 1'b0; periph_gnt_i = 1'b1;
    tick();
    periph_gnt_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total_cnt++;
    if (periph_req_o !== 1'b0 || periph_addr_o !== 32'h0 || periph_wen_o !== 1'b1 ||
        periph_wdata_o !== 32'h0 || periph_be_o !== 4'h0 || rsp_valid_o !== 1'b0 ||
        rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || cmd_ready_o !== 1'b1)
      $display("FAIL midrst_state: req=%b addr=%h wen=%b wdata=%h be=%h valid=%b rdata=%h err=%b rdy=%b required reset values",
               periph_req_o, periph_addr_o, periph_wen_o, periph_wdata_o, periph_be_o,
               rsp_valid_o, rsp_rdata_o, rsp_err_o, cmd_ready_o);
    else pass_cnt++;
    periph_r_valid_i = 1'b1; periph_r_id_i = MID; periph_r_rdata_i = 32'h11112222;
    tick();
    periph_r_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o !== 1'b0) seen_valid = 1'b1;
      if (cmd_ready_o !== 1'b1) ready_ok = 1'b0;
      tick();
    end
    $display("reset mid-op: late r_valid driven, rsp_valid seen=%b", seen_valid);
    total_cnt++;
    if (seen_valid !== 1'b0 || ready_ok !== 1'b1)
      $display("FAIL midrst_stray: rsp_valid_seen=%b cmd_ready_ok=%b required 0/1", seen_valid, ready_ok);
    else pass_cnt++;
  endtask

  // Random transactions against a latency/response model derived from the protocol rules.
  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic we = 1'($urandom);
      logic [31:0] addr = $urandom, wdata = $urandom, srd = $urandom;
      logic [3:0] be = 4'($urandom);
      logic opc = ($urandom_range(0, 3) == 0);
      int g = $urandom_range(0, 3), w = $urandom_range(0, 3), rd = $urandom_range(0, 2);
      logic junk = 1'($urandom);
      logic [31:0] exp_rdata = we ? 32'h0 : srd;
      int exp_lat = 3 + g + w;
      run_txn(we, addr, wdata, be, g, w, srd, opc, rd, junk);
      $display("rand %0d: we=%b addr=%h g=%0d w=%0d lat=%0d/%0d rdata=%h/%h err=%b/%b",
               t, we, addr, g, w, o_lat, exp_lat, o_rdata, exp_rdata, o_err, opc);
      total_cnt++;
      if (o_bus_ok !== 1'b1 || o_req_cycles != g + 1 || o_rdy_before !== 1'b1)
        $display("FAIL rand_bus[%0d]: bus_ok=%b req_cycles=%0d ready=%b required 1/%0d/1",
                 t, o_bus_ok, o_req_cycles, o_rdy_before, g + 1);
      else pass_cnt++;
      total_cnt++;
      if (o_lat != exp_lat) $display("FAIL rand_lat[%0d]: got %0d required %0d", t, o_lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (o_rdata !== exp_rdata || o_err !== opc || o_hold_ok !== 1'b1)
        $display("FAIL rand_rsp[%0d]: rdata=%h err=%b hold=%b required %h/%b/1",
                 t, o_rdata, o_err, o_hold_ok, exp_rdata, opc);
      else pass_cnt++;
    end
  endtask

`ifdef PERIPH_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 1, lat = -1;
    logic stray = 1'b0;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h10204400; cmd_be_i = 4'hF;
    tick();
    cmd_valid_i = 1'b0; periph_gnt_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid_o === 1'b1) begin lat = cyc; break; end
      tick(); cyc++; periph_gnt_i = 1'b0;
    end
    $display("timeout: rsp after %0d cycles from REQ entry, rdata=%h err=%b", lat - 1, rsp_rdata_o, rsp_err_o);
    total_cnt++;
    if (lat - 1 != TB_TO || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b1 || periph_req_o !== 1'b0)
      $display("FAIL timeout_rsp: cycles=%0d rdata=%h err=%b req=%b required %0d/0/1/0",
               lat - 1, rsp_rdata_o, rsp_err_o, periph_req_o, TB_TO);
    else pass_cnt++;
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    periph_r_valid_i = 1'b1; periph_r_id_i = MID; periph_r_rdata_i = 32'h77778888;
    tick();
    periph_r_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o !== 1'b0) stray = 1'b1;
      tick();
    end
    total_cnt++;
    if (stray !== 1'b0) $display("FAIL timeout_stray: rsp_valid seen=%b required 0", stray);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_err_id_filter();
    test_reset_mid();
    test_random();
`ifdef PERIPH_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
